// File: rtl/minibyte_regram_master_pkg.sv
// minibyte_regram_master_pkg: command opcodes and FSM state encodings shared by the RAM initiator
package minibyte_regram_master_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_SUM   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FILL,
        S_SUM,
        S_RSP
    } state_t;

endpackage

// File: rtl/minibyte_sweep_cnt.sv
// minibyte_sweep_cnt: address counter walking the whole register RAM during FILL and SUM
module minibyte_sweep_cnt #(
    parameter int ADDR_W = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    assign last = &count;

    // clear wins over enable; the counter wraps to 0 after the last address
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/minibyte_regram_master.sv
// minibyte_regram_master: command-driven initiator sequencing the register RAM port
module minibyte_regram_master
    import minibyte_regram_master_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, cnt;
    logic [DATA_W-1:0] wdata_q, acc_q;
    logic              take, sweep, last;

    assign take      = cmd_valid && (state_q == S_IDLE);
    assign ram_addr  = sweep ? cnt : addr_q;
    assign ram_wdata = wdata_q;

    minibyte_sweep_cnt #(.ADDR_W(ADDR_W)) u_cnt (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clr    (take),
        .en     (sweep),
        .count  (cnt),
        .last   (last)
    );

    // state register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // next state and RAM/handshake strobes, decoded from state only
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        sweep     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = cmd_op == OP_READ  ? S_RD :
                              cmd_op == OP_WRITE ? S_WR :
                              cmd_op == OP_FILL  ? S_FILL : S_SUM;
            end
            S_RD, S_WR: begin
                ram_en  = 1'b1;
                ram_we  = state_q == S_WR;
                state_d = S_RSP;
            end
            S_FILL, S_SUM: begin
                ram_en = 1'b1;
                ram_we = state_q == S_FILL;
                sweep  = 1'b1;
                if (last)
                    state_d = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // command latch, sum accumulator and response register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            acc_q    <= '0;
            rsp_data <= '0;
        end else begin
            if (take) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                acc_q   <= '0;
            end
            if (state_q == S_SUM)
                acc_q <= acc_q + ram_rdata;
            if (state_q == S_RD)
                rsp_data <= ram_rdata;
            if (state_q == S_WR || state_q == S_FILL)
                rsp_data <= wdata_q;
            if (state_q == S_SUM && last)
                rsp_data <= acc_q + ram_rdata;
        end
    end

endmodule

// File: doc/minibyte_regram_master.md
# minibyte_regram_master

Command-driven initiator for the 8-byte register RAM port (address / data_in / we_in / en_in / data_out). It accepts single-register READ and WRITE commands and two sweep commands, FILL and SUM, over a valid/ready handshake. It sequences the RAM port cycle by cycle and returns one response per command over a second valid/ready handshake. It sits between the MiniByte control/debug logic and the register RAM, and is the only driver of that RAM's port.

## Interface
- DATA_W, 8, RAM data width; also the response width
- ADDR_W, 3, RAM address width; sweep depth is 2^ADDR_W
- clk_in  input  1  clock, all state changes on rising edge
- rst_in  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clock edge
- cmd_op  input  2  00 READ, 01 WRITE, 10 FILL, 11 SUM
- cmd_addr  input  ADDR_W  target register (READ/WRITE only)
- cmd_wdata  input  DATA_W  write/fill value
- rsp_valid  output  1  response present, held until taken
- rsp_ready  input  1  response taken when rsp_valid && rsp_ready at a clock edge
- rsp_data  output  DATA_W  READ: register value; WRITE/FILL: echoed value; SUM: sum
- ram_addr  output  ADDR_W  to RAM address
- ram_wdata  output  DATA_W  to RAM data_in
- ram_we  output  1  to RAM we_in
- ram_en  output  1  to RAM en_in
- ram_rdata  input  DATA_W  from RAM data_out (combinational read)

## Operation
- States: IDLE, RD, WR, FILL, SUM, RSP.
- IDLE: cmd_ready=1, ram_en=0, ram_we=0. On handshake, latch op/addr/wdata and go to RD/WR/FILL/SUM by cmd_op.
- RD: one cycle with ram_en=1, ram_we=0, ram_addr=latched addr. At the closing edge, capture ram_rdata into rsp_data. Go to RSP.
- WR: one cycle with ram_en=1, ram_we=1, ram_addr=addr, ram_wdata=wdata. The RAM writes at the closing edge. rsp_data=wdata. Go to RSP.
- FILL: 2^ADDR_W cycles with ram_en=1, ram_we=1, ram_wdata=wdata, ram_addr counting 0..7. Leave after address 7. rsp_data=wdata.
- SUM: 2^ADDR_W cycles with ram_en=1, ram_we=0, ram_addr 0..7. The accumulator clears on entry and adds ram_rdata at each edge, modulo 2^DATA_W (carry discarded). After address 7, rsp_data=final sum.
- RSP: rsp_valid=1, ram_en=0, cmd_ready=0. On the rsp_ready edge, go to IDLE.
- ram_we is never 1 while ram_en=0. Outside RD/WR/FILL/SUM, ram_en=0.
- cmd_ready is 0 in every state except IDLE. A new command is not accepted in the same cycle a response is taken.
- Reset values: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, ram_addr=0, ram_wdata=0, ram_we=0, ram_en=0, accumulator 0.
- Reset mid-sweep aborts immediately. Registers already written by FILL keep their values; no response is produced.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from cmd_* or rsp_ready to ram_*.
- Let edge E be the command handshake.
- READ/WRITE: RAM access occupies the cycle after E. rsp_valid is 1 from edge E+2.
- FILL/SUM: accesses occupy cycles E+1..E+8. rsp_valid is 1 from edge E+9.
- rsp_ready already high when rsp_valid rises: response is consumed at the next edge. cmd_ready returns one cycle after that edge.
- Back-to-back minimum command spacing: 3 cycles for READ/WRITE, 10 cycles for FILL/SUM.
- cmd_* is ignored while cmd_ready=0. rsp_data is stable while rsp_valid=1.

## Structure
- Shared defines file holds the op encodings (OP_READ, OP_WRITE, OP_FILL, OP_SUM) and the state encodings.
- One sub-module is natural: minibyte_sweep_cnt.
  - ADDR_W-bit counter with clear, enable and a last flag (count == 2^ADDR_W-1).
  - Drives ram_addr during FILL and SUM.
- The FSM, accumulator and response register stay in the top module.

## Test plan
- Reset, then WRITE addr 5, data 0xA7, then READ addr 5 -> RAM sees we=1 at addr 5 for exactly one cycle; READ response rsp_data=0xA7, rsp_valid at E+2.
- FILL data 0x3C, then READ addr 0 and addr 7 -> exactly 8 write cycles at addresses 0..7; both reads return 0x3C; FILL response echoes 0x3C at E+9.
- WRITE registers 0..7 with 0x20 each, then SUM -> rsp_data=0x00 (0x100 wraps); write 0x01..0x08 instead -> rsp_data=0x24.
- rsp_ready held low for 5 cycles, cmd_valid pulsed meanwhile -> rsp_valid and rsp_data hold steady; cmd_ready stays 0; no extra RAM access.
- Assert rst_in low at cycle 4 of a FILL 0xFF -> all outputs go to reset values asynchronously, no response. Afterwards registers 0..3 read 0xFF and 4..7 keep their prior values.
- Random mix of 200 commands with random rsp_ready backpressure, checked against a reference model -> every response matches; ram_we never 1 with ram_en=0.
